// File: rtl/taxi_apb_pkg.sv
// Shared types and helpers for the APB interconnect: FSM state encoding, PPROT bit positions, window match.
package taxi_apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_t;

    localparam int PPROT_W         = 3;
    localparam int PPROT_PRIV_BIT  = 0;
    localparam int PPROT_NSEC_BIT  = 1;
    localparam int PPROT_INSTR_BIT = 2;

    // Wide enough for any supported ADDR_W; narrower addresses are zero-extended.
    localparam int MATCH_W = 64;

    function automatic logic apb_addr_match(
        input logic [MATCH_W-1:0] addr,
        input logic [MATCH_W-1:0] base,
        input logic [31:0]        width
    );
        return (addr >> width) == (base >> width);
    endfunction

endpackage

// File: rtl/taxi_apb_if.sv
// APB4 signal bundle with requester (mst) and completer (slv) views.
interface taxi_apb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int STRB_W = DATA_W / 8
);
    logic [ADDR_W-1:0] paddr;
    logic [2:0]        pprot;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [DATA_W-1:0] pwdata;
    logic [STRB_W-1:0] pstrb;
    logic              pready;
    logic [DATA_W-1:0] prdata;
    logic              pslverr;

    modport mst (
        output paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
        input  pready, prdata, pslverr
    );

    modport slv (
        input  paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/taxi_apb_addr_dec.sv
// Combinational address decoder: lowest-index port whose window contains the address wins.
module taxi_apb_addr_dec
    import taxi_apb_pkg::*;
#(
    parameter int                      M_CNT       = 4,
    parameter int                      ADDR_W      = 32,
    parameter int                      SEL_W       = 2,
    parameter logic [M_CNT*ADDR_W-1:0] M_BASE_ADDR = '0,
    parameter logic [M_CNT*32-1:0]     M_ADDR_W    = {M_CNT{32'd12}}
) (
    input  logic [ADDR_W-1:0] addr_i,
    output logic              hit_o,
    output logic [SEL_W-1:0]  sel_o
);

    // Scan downwards so the last assignment standing is the lowest matching index.
    always_comb begin
        hit_o = 1'b0;
        sel_o = '0;
        for (int i = M_CNT - 1; i >= 0; i--) begin
            if (apb_addr_match(MATCH_W'(addr_i),
                               MATCH_W'(M_BASE_ADDR[i*ADDR_W +: ADDR_W]),
                               M_ADDR_W[i*32 +: 32])) begin
                hit_o = 1'b1;
                sel_o = SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/taxi_apb_interconnect.sv
// One-to-M_CNT APB interconnect with a single outstanding transfer.
// Optional ACCESS timeout enabled by defining TAXI_APB_INTERCONNECT_TIMEOUT_EN.
module taxi_apb_interconnect
    import taxi_apb_pkg::*;
#(
    parameter int                      M_CNT          = 4,
    parameter int                      DATA_W         = 32,
    parameter int                      ADDR_W         = 32,
    parameter int                      STRB_W         = DATA_W / 8,
    parameter logic [M_CNT*ADDR_W-1:0] M_BASE_ADDR    = '0,
    parameter logic [M_CNT*32-1:0]     M_ADDR_W       = {M_CNT{32'd12}},
    parameter int                      TIMEOUT_CYCLES = 1024
) (
    input  logic   clk,
    input  logic   rst,
    taxi_apb_if.slv s_apb,
    taxi_apb_if.mst m_apb [M_CNT]
);

    localparam int SEL_W = (M_CNT > 1) ? $clog2(M_CNT) : 1;

    apb_state_t        state_q;
    logic [ADDR_W-1:0] paddr_q;
    logic [PPROT_W-1:0] pprot_q;
    logic              pwrite_q;
    logic [DATA_W-1:0] pwdata_q;
    logic [STRB_W-1:0] pstrb_q;
    logic              hit_q;
    logic [SEL_W-1:0]  sel_q;
    logic              m_psel_q;
    logic              m_penable_q;
    logic              s_pready_q;
    logic              s_pslverr_q;
    logic [DATA_W-1:0] s_prdata_q;

    logic              dec_hit;
    logic [SEL_W-1:0]  dec_sel;
    logic [M_CNT-1:0]  m_pready;
    logic [M_CNT-1:0]  m_pslverr;
    logic [DATA_W-1:0] m_prdata [M_CNT];
    logic              sel_pready;
    logic              sel_pslverr;
    logic [DATA_W-1:0] sel_prdata;
    logic              to_expire;

    taxi_apb_addr_dec #(
        .M_CNT       (M_CNT),
        .ADDR_W      (ADDR_W),
        .SEL_W       (SEL_W),
        .M_BASE_ADDR (M_BASE_ADDR),
        .M_ADDR_W    (M_ADDR_W)
    ) u_dec (
        .addr_i (s_apb.paddr),
        .hit_o  (dec_hit),
        .sel_o  (dec_sel)
    );

    for (genvar i = 0; i < M_CNT; i++) begin : g_port
        assign m_apb[i].psel    = m_psel_q    && (sel_q == SEL_W'(i));
        assign m_apb[i].penable = m_penable_q && (sel_q == SEL_W'(i));
        assign m_apb[i].paddr   = paddr_q;
        assign m_apb[i].pprot   = pprot_q;
        assign m_apb[i].pwrite  = pwrite_q;
        assign m_apb[i].pwdata  = pwdata_q;
        assign m_apb[i].pstrb   = pstrb_q;
        assign m_pready[i]      = m_apb[i].pready;
        assign m_pslverr[i]     = m_apb[i].pslverr;
        assign m_prdata[i]      = m_apb[i].prdata;
    end

    // Compare-based mux keeps non-power-of-two M_CNT from indexing past the array.
    always_comb begin
        sel_pready  = 1'b0;
        sel_pslverr = 1'b0;
        sel_prdata  = '0;
        for (int i = 0; i < M_CNT; i++) begin
            if (sel_q == SEL_W'(i)) begin
                sel_pready  = m_pready[i];
                sel_pslverr = m_pslverr[i];
                sel_prdata  = m_prdata[i];
            end
        end
    end

    assign s_apb.pready  = s_pready_q;
    assign s_apb.pslverr = s_pslverr_q;
    assign s_apb.prdata  = s_prdata_q;

`ifdef TAXI_APB_INTERCONNECT_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt_q;

    assign to_expire = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

    // Counts downstream cycles with penable high and no pready; SETUP always precedes ACCESS.
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt_q <= '0;
        end else if (state_q == ST_SETUP) begin
            to_cnt_q <= '0;
        end else if (state_q == ST_ACCESS && m_penable_q && !sel_pready) begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
        end
    end
`else
    assign to_expire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            paddr_q     <= '0;
            pprot_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            pstrb_q     <= '0;
            hit_q       <= 1'b0;
            sel_q       <= '0;
            m_psel_q    <= 1'b0;
            m_penable_q <= 1'b0;
            s_pready_q  <= 1'b0;
            s_pslverr_q <= 1'b0;
            s_prdata_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (s_apb.psel && !s_apb.penable) begin
                        paddr_q  <= s_apb.paddr;
                        pprot_q  <= s_apb.pprot;
                        pwrite_q <= s_apb.pwrite;
                        pwdata_q <= s_apb.pwdata;
                        pstrb_q  <= s_apb.pstrb;
                        hit_q    <= dec_hit;
                        sel_q    <= dec_sel;
                        state_q  <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (hit_q) begin
                        m_psel_q    <= 1'b1;
                        m_penable_q <= 1'b0;
                        state_q     <= ST_ACCESS;
                    end else begin
                        s_prdata_q  <= '0;
                        s_pslverr_q <= 1'b1;
                        s_pready_q  <= 1'b1;
                        state_q     <= ST_RESP;
                    end
                end
                ST_ACCESS: begin
                    // First ACCESS cycle is the downstream setup phase.
                    if (!m_penable_q) begin
                        m_penable_q <= 1'b1;
                    end else if (sel_pready || to_expire) begin
                        m_psel_q    <= 1'b0;
                        m_penable_q <= 1'b0;
                        s_prdata_q  <= sel_pready ? sel_prdata : '0;
                        s_pslverr_q <= sel_pready ? sel_pslverr : 1'b1;
                        s_pready_q  <= 1'b1;
                        state_q     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    s_pready_q <= 1'b0;
                    state_q    <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_taxi_apb_interconnect.sv
// Randomized self-checking bench for taxi_apb_interconnect against a window-decode reference model.
module tb_taxi_apb_interconnect;

    localparam logic [127:0] BASES = {32'h3000, 32'h2000, 32'h1000, 32'h0000};

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    taxi_apb_if #(.DATA_W(32), .ADDR_W(32)) s_apb ();
    taxi_apb_if #(.DATA_W(32), .ADDR_W(32)) m_apb [4] ();

    taxi_apb_interconnect #(
        .M_CNT          (4),
        .DATA_W         (32),
        .ADDR_W         (32),
        .M_BASE_ADDR    (BASES),
        .M_ADDR_W       ({4{32'd12}}),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .s_apb (s_apb),
        .m_apb (m_apb)
    );

    // Per-port completer behaviour
    int          ws    [4];
    logic [31:0] rd    [4];
    bit          err   [4];
    bit          hang  [4];
    bit          noise [4];

    logic [3:0]        m_psel, m_pen, m_rdy, m_write;
    logic [3:0][31:0]  m_addr, m_wdata;
    logic [3:0][3:0]   m_strb;
    logic [3:0][2:0]   m_prot;

    for (genvar g = 0; g < 4; g++) begin : g_rsp
        int wcnt = 0;
        always @(posedge clk) begin
            if (!m_apb[g].psel) wcnt <= 0;
            else if (m_apb[g].penable && !m_apb[g].pready) wcnt <= wcnt + 1;
        end
        assign m_apb[g].pready  = (m_apb[g].psel && m_apb[g].penable && !hang[g] && (wcnt >= ws[g]))
                                  || noise[g];
        assign m_apb[g].prdata  = rd[g];
        assign m_apb[g].pslverr = err[g];
        assign m_psel[g]  = m_apb[g].psel;
        assign m_pen[g]   = m_apb[g].penable;
        assign m_rdy[g]   = m_apb[g].pready;
        assign m_write[g] = m_apb[g].pwrite;
        assign m_addr[g]  = m_apb[g].paddr;
        assign m_wdata[g] = m_apb[g].pwdata;
        assign m_strb[g]  = m_apb[g].pstrb;
        assign m_prot[g]  = m_apb[g].pprot;
    end

    // Cumulative downstream activity, diffed around each transfer
    int          psel_n [4];
    int          setup_n[4];
    int          pen_n  [4];
    int          bad_pen = 0;
    logic [31:0] last_addr [4];
    logic [31:0] last_wdata[4];
    logic [3:0]  last_strb [4];
    logic [2:0]  last_prot [4];
    logic        last_write[4];

    initial for (int i = 0; i < 4; i++) begin
        psel_n[i] = 0; setup_n[i] = 0; pen_n[i] = 0;
    end

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (m_psel[i]) begin
                psel_n[i] <= psel_n[i] + 1;
                if (!m_pen[i]) setup_n[i] <= setup_n[i] + 1;
                else           pen_n[i]   <= pen_n[i] + 1;
                if (m_pen[i] && m_rdy[i]) begin
                    last_addr[i]  <= m_addr[i];
                    last_wdata[i] <= m_wdata[i];
                    last_strb[i]  <= m_strb[i];
                    last_prot[i]  <= m_prot[i];
                    last_write[i] <= m_write[i];
                end
            end
            if (m_pen[i] && !m_psel[i]) bad_pen <= bad_pen + 1;
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference decode: 4 KiB windows at the configured bases, lowest index first
    function automatic int model_port(input logic [31:0] addr);
        logic [31:0] base [4];
        base = '{32'h0000, 32'h1000, 32'h2000, 32'h3000};
        for (int i = 0; i < 4; i++)
            if ((addr / 32'h1000) == (base[i] / 32'h1000)) return i;
        return -1;
    endfunction

    // Upstream requester; entered and left #1 after a rising edge
    task automatic apb_xfer(input logic [31:0] addr, input bit wr, input logic [31:0] wdata,
                            input logic [3:0] strb, input logic [2:0] prot, input int budget,
                            output logic [31:0] rdata, output bit e, output int lat, output bit done);
        s_apb.paddr   = addr;
        s_apb.pwrite  = wr;
        s_apb.pwdata  = wdata;
        s_apb.pstrb   = strb;
        s_apb.pprot   = prot;
        s_apb.psel    = 1'b1;
        s_apb.penable = 1'b0;
        done = 0; lat = 0; rdata = '0; e = 0;
        @(posedge clk); #1;
        s_apb.penable = 1'b1;
        for (int n = 1; n <= budget && !done; n++) begin
            if (s_apb.pready) begin
                done  = 1;
                lat   = n;
                rdata = s_apb.prdata;
                e     = s_apb.pslverr;
            end else begin
                @(posedge clk); #1;
            end
        end
        if (done) begin
            @(posedge clk); #1;
            s_apb.psel    = 1'b0;
            s_apb.penable = 1'b0;
            chk("pready_one_cycle", 64'(s_apb.pready), 64'd0);
        end
    endtask

    task automatic run_one(input string tag, input logic [31:0] addr, input bit wr,
                           input logic [31:0] wdata, input logic [3:0] strb, input logic [2:0] prot);
        int p, lat, oth;
        int ps0[4], st0[4], pe0[4];
        logic [31:0] rdata;
        bit e, done;
        p = model_port(addr);
        for (int i = 0; i < 4; i++) begin
            noise[i] = (i != p) && ($urandom_range(0, 1) == 1);
            ps0[i] = psel_n[i]; st0[i] = setup_n[i]; pe0[i] = pen_n[i];
        end
        apb_xfer(addr, wr, wdata, strb, prot, 64, rdata, e, lat, done);
        for (int i = 0; i < 4; i++) noise[i] = 0;
        chk({tag, "_done"}, 64'(done), 64'd1);
        oth = 0;
        for (int i = 0; i < 4; i++) if (i != p) oth += psel_n[i] - ps0[i];
        chk({tag, "_other_psel"}, 64'(oth), 64'd0);
        if (p < 0) begin
            chk({tag, "_lat"},    64'(lat),   64'd2);
            chk({tag, "_err"},    64'(e),     64'd1);
            chk({tag, "_rdata"},  64'(rdata), 64'd0);
        end else begin
            chk({tag, "_lat"},    64'(lat),   64'(4 + ws[p]));
            chk({tag, "_err"},    64'(e),     64'(err[p]));
            if (!wr) chk({tag, "_rdata"}, 64'(rdata), 64'(rd[p]));
            chk({tag, "_setup"},  64'(setup_n[p] - st0[p]), 64'd1);
            chk({tag, "_access"}, 64'(pen_n[p] - pe0[p]),   64'(ws[p] + 1));
            chk({tag, "_paddr"},  64'(last_addr[p]),  64'(addr));
            chk({tag, "_pwrite"}, 64'(last_write[p]), 64'(wr));
            chk({tag, "_pprot"},  64'(last_prot[p]),  64'(prot));
            if (wr) begin
                chk({tag, "_pwdata"}, 64'(last_wdata[p]), 64'(wdata));
                chk({tag, "_pstrb"},  64'(last_strb[p]),  64'(strb));
            end
        end
    endtask

    initial begin
        logic [31:0] rdata, addr;
        bit e, done;
        int lat, pe0;

        for (int i = 0; i < 4; i++) begin
            ws[i] = 0; rd[i] = 32'h0; err[i] = 0; hang[i] = 0; noise[i] = 0;
        end
        s_apb.psel = 0; s_apb.penable = 0; s_apb.paddr = '0; s_apb.pwrite = 0;
        s_apb.pwdata = '0; s_apb.pstrb = '0; s_apb.pprot = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_psel",    64'(m_psel),         64'd0);
        chk("rst_penable", 64'(m_pen),          64'd0);
        chk("rst_pready",  64'(s_apb.pready),   64'd0);
        chk("rst_pslverr", 64'(s_apb.pslverr),  64'd0);
        chk("rst_prdata",  64'(s_apb.prdata),   64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        ws[1] = 0; rd[1] = 32'hA5A5_0001;
        run_one("wr_port1", 32'h1004, 1'b1, 32'hDEADBEEF, 4'hF, 3'b000);

        ws[3] = 3; rd[3] = 32'h12345678;
        run_one("rd_port3_ws3", 32'h3010, 1'b0, 32'h0, 4'h0, 3'b001);

        run_one("rd_miss", 32'h8000, 1'b0, 32'h0, 4'h0, 3'b000);

        ws[2] = 1; err[2] = 1;
        run_one("wr_port2_err", 32'h2000, 1'b1, 32'h0BAD_F00D, 4'h3, 3'b010);
        err[2] = 0;

        // Port 0 never responds
        hang[0] = 1; rd[0] = 32'hCAFE_0000;
        pe0 = pen_n[0];
`ifdef TAXI_APB_INTERCONNECT_TIMEOUT_EN
        apb_xfer(32'h0000, 1'b0, 32'h0, 4'h0, 3'b000, 64, rdata, e, lat, done);
        chk("to_done",    64'(done),             64'd1);
        chk("to_lat",     64'(lat),              64'd19);
        chk("to_access",  64'(pen_n[0] - pe0),   64'd16);
        chk("to_err",     64'(e),                64'd1);
        chk("to_rdata",   64'(rdata),            64'd0);
        chk("to_psel",    64'(m_psel),           64'd0);
`else
        apb_xfer(32'h0000, 1'b0, 32'h0, 4'h0, 3'b000, 40, rdata, e, lat, done);
        chk("hang_done",    64'(done),         64'd0);
        chk("hang_psel",    64'(m_psel),       64'd1);
        chk("hang_penable", 64'(m_pen),        64'd1);
        chk("hang_pready",  64'(s_apb.pready), 64'd0);
        rst = 1'b1;
        s_apb.psel = 0; s_apb.penable = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("hang_rst_psel", 64'(m_psel), 64'd0);
        @(posedge clk); #1;
`endif
        hang[0] = 0;

        // Reset in the middle of an ACCESS phase
        ws[0] = 5; rd[0] = 32'h0000_1111;
        s_apb.paddr = 32'h0008; s_apb.pwrite = 0; s_apb.psel = 1; s_apb.penable = 0;
        @(posedge clk); #1;
        s_apb.penable = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_access_penable", 64'(m_pen), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_psel",   64'(m_psel),        64'd0);
        chk("abort_pready", 64'(s_apb.pready),  64'd0);
        chk("abort_prdata", 64'(s_apb.prdata),  64'd0);
        rst = 1'b0;
        s_apb.psel = 0; s_apb.penable = 0;
        @(posedge clk); #1;
        ws[1] = 1; rd[1] = 32'h7777_1000;
        run_one("post_rst_rd", 32'h1000, 1'b0, 32'h0, 4'h0, 3'b000);

        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < 4; i++) begin
                ws[i]  = $urandom_range(0, 3);
                rd[i]  = $urandom;
                err[i] = ($urandom_range(0, 3) == 0);
            end
            if ($urandom_range(0, 4) == 0) addr = $urandom_range(32'h4000, 32'hFFFF_FFFF);
            else                           addr = $urandom_range(0, 32'h3FFF);
            run_one("rand", addr, 1'($urandom_range(0, 1)), $urandom,
                    4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        chk("no_stray_penable", 64'(bad_pen), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
